// File: rtl/dmem_responder.sv
// Data-memory responder: registered word loads, byte/half/word stores with
// lane strobes, write-first read bypass and a sticky first-fault register.
module dmem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  wr_size,
  output logic        fault,
  output logic [31:0] fault_addr,
  input  logic        fault_clr
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LANES = 4;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   rd_off;
  logic [31:0]   wr_off;
  logic          rd_in_range;
  logic          wr_in_range;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  logic [3:0]    wr_strb;
  logic [31:0]   wr_word;
  logic          wr_misaligned;
  logic          wr_ok;
  logic          wr_fault;
  logic          rd_fault;
  logic [31:0]   rd_merged;

  // Address decode relative to the window base
  assign rd_off      = rd_addr - BASE_ADDR;
  assign wr_off      = wr_addr - BASE_ADDR;
  assign rd_in_range = (rd_off >> (AW + 2)) == 32'd0;
  assign wr_in_range = (wr_off >> (AW + 2)) == 32'd0;
  assign rd_idx      = rd_off[AW+1:2];
  assign wr_idx      = wr_off[AW+1:2];

  // Size decode: strobes, lane-replicated data and alignment check
  always_comb begin
    wr_strb       = 4'b0000;
    wr_word       = wr_data;
    wr_misaligned = 1'b0;
    if (!wr_size[0]) begin
      wr_strb       = 4'b1111;
      wr_word       = wr_data;
      wr_misaligned = |wr_addr[1:0];
    end else if (!wr_size[1]) begin
      wr_strb       = wr_addr[1] ? 4'b1100 : 4'b0011;
      wr_word       = {2{wr_data[15:0]}};
      wr_misaligned = wr_addr[0];
    end else begin
      wr_strb       = 4'b0001 << wr_addr[1:0];
      wr_word       = {4{wr_data[7:0]}};
      wr_misaligned = 1'b0;
    end
  end

  assign wr_ok    = wr_en & wr_in_range & ~wr_misaligned;
  assign wr_fault = wr_en & ~(wr_in_range & ~wr_misaligned);
  assign rd_fault = rd_en & ~rd_in_range;

  // Write-first bypass: overlay the committing store onto the read word
  always_comb begin
    rd_merged = mem[rd_idx];
    for (int i = 0; i < LANES; i++) begin
      if (wr_ok && (wr_idx == rd_idx) && wr_strb[i]) begin
        rd_merged[8*i +: 8] = wr_word[8*i +: 8];
      end
    end
  end

  // Array is not reset; stores are dropped while reset is asserted
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_strb[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_word[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 32'd0;
    end else if (rd_en) begin
      rd_data <= rd_in_range ? rd_merged : 32'd0;
    end
  end

  // Sticky fault: first address kept; a new event beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_addr <= 32'd0;
    end else if ((wr_fault || rd_fault) && (!fault || fault_clr)) begin
      fault      <= 1'b1;
      fault_addr <= wr_fault ? wr_addr : rd_addr;
    end else if (fault_clr) begin
      fault      <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, wr_size[2], rd_off[1:0], wr_off[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder with hand-computed
// expectations plus a reset-mid-stream sequence.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] B     = 32'h0000_1000;
  localparam logic [2:0]  SZ_W  = 3'b000;
  localparam logic [2:0]  SZ_H  = 3'b001;
  localparam logic [2:0]  SZ_B  = 3'b011;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  wr_size;
  logic        fault;
  logic [31:0] fault_addr;
  logic        fault_clr;

  int checks;
  int failures;

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_size    (wr_size),
    .fault      (fault),
    .fault_addr (fault_addr),
    .fault_clr  (fault_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  wr_size;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        fault_clr;
    logic [31:0] exp_rd;
    logic        exp_fault;
    logic [31:0] exp_faddr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] e_rd, input logic e_f,
                          input logic [31:0] e_fa);
    chk({tag, ".rd_data"}, rd_data, e_rd);
    chk({tag, ".fault"}, 32'(fault), 32'(e_f));
    chk({tag, ".fault_addr"}, fault_addr, e_fa);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0; wr_size = SZ_W;
    rd_en = 1'b0; rd_addr = 32'd0; fault_clr = 1'b0;
  endtask

  task automatic add(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [2:0] ws, input logic re, input logic [31:0] ra,
                     input logic clr, input logic [31:0] erd, input logic ef,
                     input logic [31:0] efa);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_size = ws;
    v.rd_en = re; v.rd_addr = ra; v.fault_clr = clr;
    v.exp_rd = erd; v.exp_fault = ef; v.exp_faddr = efa;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample just after the edge that took them
  task automatic apply(input vec_t v, input string tag);
    wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data; wr_size = v.wr_size;
    rd_en = v.rd_en; rd_addr = v.rd_addr; fault_clr = v.fault_clr;
    @(posedge clk);
    #1;
    chk_outs(tag, v.exp_rd, v.exp_fault, v.exp_faddr);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst_n = 1'b0;

    //  we   wr_addr     wr_data        size  re  rd_addr     clr  exp_rd        f   fault_addr
    add(1, B+32'h10,  32'hDEAD_BEEF, SZ_W, 0, 32'h0,     0, 32'h0,        0, 32'h0);
    add(0, 32'h0,     32'h0,         SZ_W, 1, B+32'h10,  0, 32'hDEAD_BEEF,0, 32'h0);
    add(1, B+32'h20,  32'h1122_3344, SZ_W, 0, 32'h0,     0, 32'hDEAD_BEEF,0, 32'h0);
    add(1, B+32'h22,  32'h1234_56AA, SZ_B, 0, 32'h0,     0, 32'hDEAD_BEEF,0, 32'h0);
    add(0, 32'h0,     32'h0,         SZ_W, 1, B+32'h20,  0, 32'h11AA_3344,0, 32'h0);
    add(1, B+32'h20,  32'h9999_BEEF, SZ_H, 0, 32'h0,     0, 32'h11AA_3344,0, 32'h0);
    add(0, 32'h0,     32'h0,         SZ_W, 1, B+32'h23,  0, 32'h11AA_BEEF,0, 32'h0);
    add(1, B+32'h30,  32'h0,         SZ_W, 0, 32'h0,     0, 32'h11AA_BEEF,0, 32'h0);
    add(1, B+32'h31,  32'h0000_005A, SZ_B, 1, B+32'h30,  0, 32'h0000_5A00,0, 32'h0);
    add(1, B+32'h32,  32'hFFFF_1234, SZ_H, 1, B+32'h30,  0, 32'h1234_5A00,0, 32'h0);
    add(1, B+32'h40,  32'h5566_7788, SZ_W, 0, 32'h0,     0, 32'h1234_5A00,0, 32'h0);
    add(1, B+32'h41,  32'hFFFF_FFFF, SZ_W, 0, 32'h0,     0, 32'h1234_5A00,1, B+32'h41);
    add(0, 32'h0,     32'h0,         SZ_W, 1, B+32'h40,  0, 32'h5566_7788,1, B+32'h41);
    add(1, B+32'h43,  32'h0000_AAAA, SZ_H, 0, 32'h0,     0, 32'h5566_7788,1, B+32'h41);
    add(0, 32'h0,     32'h0,         SZ_W, 1, B+32'h40,  0, 32'h5566_7788,1, B+32'h41);
    add(0, 32'h0,     32'h0,         SZ_W, 0, 32'h0,     1, 32'h5566_7788,0, B+32'h41);
    add(0, 32'h0,     32'h0,         SZ_W, 1, B+32'h400, 0, 32'h0,        1, B+32'h400);
    add(0, 32'h0,     32'h0,         SZ_W, 0, 32'h0,     1, 32'h0,        0, B+32'h400);
    add(1, B+32'h45,  32'h0000_1111, SZ_H, 0, 32'h0,     1, 32'h0,        1, B+32'h45);
    add(0, 32'h0,     32'h0,         SZ_W, 0, 32'h0,     1, 32'h0,        0, B+32'h45);
    add(1, B+32'h402, 32'h0,         SZ_W, 1, B-32'h4,   0, 32'h0,        1, B+32'h402);
    add(0, 32'h0,     32'h0,         SZ_W, 0, 32'h0,     1, 32'h0,        0, B+32'h402);
    add(1, B+32'h3FC, 32'hCAFE_F00D, SZ_W, 0, 32'h0,     0, 32'h0,        0, B+32'h402);
    add(0, 32'h0,     32'h0,         SZ_W, 1, B+32'h3FC, 0, 32'hCAFE_F00D,0, B+32'h402);
    add(1, B+32'h13,  32'h0000_0077, SZ_B, 1, B+32'h10,  0, 32'h77AD_BEEF,0, B+32'h402);
    add(0, 32'h0,     32'h0,         SZ_W, 0, 32'h0,     0, 32'h77AD_BEEF,0, B+32'h402);
    add(0, 32'h0,     32'h0,         SZ_W, 1, B+32'h20,  0, 32'h11AA_BEEF,0, B+32'h402);
    add(0, 32'h0,     32'h0,         SZ_W, 1, B+32'h10,  0, 32'h77AD_BEEF,0, B+32'h402);
    add(1, B+32'h42,  32'hFFFF_FFFF, SZ_W, 1, B+32'h40,  0, 32'h5566_7788,1, B+32'h42);
    add(0, 32'h0,     32'h0,         SZ_W, 0, 32'h0,     1, 32'h5566_7788,0, B+32'h42);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Reset mid-stream: outputs clear at once, store under reset is dropped
    rd_en = 1'b1; rd_addr = B + 32'h20;
    fault_clr = 1'b0;
    wr_en = 1'b1; wr_addr = B + 32'h41; wr_data = 32'h0; wr_size = SZ_W;
    @(posedge clk);
    #1;
    chk_outs("pre_rst", 32'h11AA_BEEF, 1'b1, B + 32'h41);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 32'h0, 1'b0, 32'h0);
    wr_en = 1'b1; wr_addr = B + 32'h20; wr_data = 32'hBAD0_BAD0; wr_size = SZ_W;
    @(posedge clk);
    #1;
    chk_outs("held_rst", 32'h0, 1'b0, 32'h0);
    idle_inputs();
    rst_n = 1'b1;

    v = '{wr_en:0, wr_addr:0, wr_data:0, wr_size:SZ_W, rd_en:1, rd_addr:B+32'h20,
          fault_clr:0, exp_rd:32'h11AA_BEEF, exp_fault:0, exp_faddr:0};
    apply(v, "post_rst_a");
    v.rd_addr = B + 32'h10; v.exp_rd = 32'h77AD_BEEF;
    apply(v, "post_rst_b");
    v.rd_addr = B + 32'h3FC; v.exp_rd = 32'hCAFE_F00D;
    apply(v, "post_rst_c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
